// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host writes and hands bytes
// to the UART one at a time, pacing on TXbusy so no byte is lost or overlapped.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf,
  input  logic          flush,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic          sending
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          sending_q, sending_d;
  logic          pop, wr_ok, wr_drop;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign sending  = sending_q;

  // A pop frees a slot on the same edge, so a write into a full FIFO is legal then.
  always_comb begin
    pop     = (state_q == IDLE) && !empty && !flush;
    wr_ok   = wr_en && !flush && (!full || pop);
    wr_drop = wr_en && !flush && full && !pop;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    sending_d  = sending_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (wr_ok && !pop) begin
        level_d = level_q + LVL_ONE;
      end else if (pop && !wr_ok) begin
        level_d = level_q - LVL_ONE;
      end
    end

    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          sending_d  = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          sending_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        sending_d  = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // Storage array is not reset; only pointers and level define its contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      sending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      sending_q  <= sending_d;
    end
    mem_q <= mem_d;
  end

endmodule
